// File: rtl/branch_resolve_unit_pkg.sv
// Shared sizes and state encoding for the branch resolve unit.
package branch_resolve_unit_pkg;

    // Default address width and prediction-queue sizing, kept in step with the BLT.
    localparam int BRU_ADDR_WIDTH = 16;
    localparam int BRU_DEPTH      = 8;
    localparam int BRU_DEPTH_LOG2 = 3;

    // Occupancy state of the prediction queue.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FULL  = 2'd2
    } bru_state_t;

endpackage

// File: rtl/branch_resolve_unit_pred_fifo.sv
// In-order store of fetch-time predictions {pc, taken, target}.
// A clear input empties the queue in one edge for mispredict recovery.
module branch_resolve_unit_pred_fifo #(
    parameter int W          = 33,
    parameter int DEPTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [W-1:0]          wr_data,
    input  logic                  rd_en,
    output logic [W-1:0]          rd_data,
    output logic [DEPTH_LOG2:0]   count
);

    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;

    // Pointer and occupancy bookkeeping; clear and reset both empty the queue.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: checks each fetch-time prediction against the executed
// outcome in program order, trains the BLT, and redirects fetch on a mispredict.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = BRU_ADDR_WIDTH,
    parameter int DEPTH      = BRU_DEPTH,
    parameter int DEPTH_LOG2 = BRU_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    input  logic                  push_taken,
    input  logic [ADDR_WIDTH-1:0] push_target,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    input  logic                  resolve,
    input  logic [ADDR_WIDTH-1:0] resolve_pc,
    input  logic                  resolve_taken,
    input  logic [ADDR_WIDTH-1:0] resolve_target,
    output logic                  blt_write,
    output logic [ADDR_WIDTH-1:0] blt_write_key,
    output logic [ADDR_WIDTH-1:0] blt_write_val,
    output logic                  blt_hit,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] flush_pc,
    output logic                  error
);

    localparam int                ENTRY_W   = 2 * ADDR_WIDTH + 1;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    // Corrected fetch address: the real target if taken, else the fall-through.
    function automatic logic [ADDR_WIDTH-1:0] redirect_pc(
        input logic                  taken,
        input logic [ADDR_WIDTH-1:0] target,
        input logic [ADDR_WIDTH-1:0] pc
    );
        return taken ? target : pc + 1'b1;
    endfunction

    bru_state_t            state;
    bru_state_t            state_next;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  empty;

    logic [ENTRY_W-1:0]    head;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic                  head_taken;
    logic [ADDR_WIDTH-1:0] head_target;

    logic                  pop;
    logic                  pc_mismatch;
    logic                  mispredict;
    logic                  do_flush;
    logic                  train;
    logic                  push_ok;
    logic                  overflow;
    logic                  err_next;

    assign {head_pc, head_taken, head_target} = head;

    assign full  = (state == ST_FULL);
    assign empty = (state == ST_IDLE);

    // Resolve decision for the oldest prediction, all derived from the head entry.
    always_comb begin
        pop         = resolve & ~empty;
        pc_mismatch = pop & (head_pc != resolve_pc);
        mispredict  = (head_taken != resolve_taken) |
                      (resolve_taken & (head_target != resolve_target));
        do_flush    = pop & (pc_mismatch | mispredict);
        train       = pop & ~pc_mismatch;
        // A push in the same cycle as a redirect is on the wrong path and is dropped silently.
        push_ok     = push & (~full | pop) & ~do_flush;
        overflow    = push & full & ~pop;
        err_next    = (resolve & empty) | overflow | pc_mismatch;
    end

    branch_resolve_unit_pred_fifo #(
        .W          (ENTRY_W),
        .DEPTH      (DEPTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_pred_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (do_flush),
        .wr_en   (push_ok),
        .wr_data ({push_pc, push_taken, push_target}),
        .rd_en   (pop),
        .rd_data (head),
        .count   (count)
    );

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next occupancy and state, tracking the queue count edge for edge.
    always_comb begin
        count_next = count;
        state_next = state;
        if (do_flush)            count_next = '0;
        else if (push_ok && !pop) count_next = count + 1'b1;
        else if (!push_ok && pop) count_next = count - 1'b1;

        if (do_flush || count_next == '0) state_next = ST_IDLE;
        else if (count_next == DEPTH_CNT)  state_next = ST_FULL;
        else                               state_next = ST_TRACK;
    end

    // Registered outputs: strobes pulse for one cycle, payloads hold until the next strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            blt_write     <= 1'b0;
            blt_write_key <= '0;
            blt_write_val <= '0;
            blt_hit       <= 1'b0;
            flush         <= 1'b0;
            flush_pc      <= '0;
            error         <= 1'b0;
        end else begin
            blt_write <= train;
            flush     <= do_flush;
            error     <= err_next;
            if (train) begin
                blt_write_key <= resolve_pc;
                blt_write_val <= resolve_target;
                blt_hit       <= resolve_taken;
            end
            if (do_flush) begin
                flush_pc <= redirect_pc(resolve_taken, resolve_target, resolve_pc);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a queue-based reference model
// predicts every registered output for each driven cycle.
module tb_branch_resolve_unit;

    localparam int AW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic [AW-1:0] push_pc;
    logic          push_taken;
    logic [AW-1:0] push_target;
    logic          full;
    logic [3:0]    count;
    logic          resolve;
    logic [AW-1:0] resolve_pc;
    logic          resolve_taken;
    logic [AW-1:0] resolve_target;
    logic          blt_write;
    logic [AW-1:0] blt_write_key;
    logic [AW-1:0] blt_write_val;
    logic          blt_hit;
    logic          flush;
    logic [AW-1:0] flush_pc;
    logic          error;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk            (clk),
        .reset          (reset),
        .push           (push),
        .push_pc        (push_pc),
        .push_taken     (push_taken),
        .push_target    (push_target),
        .full           (full),
        .count          (count),
        .resolve        (resolve),
        .resolve_pc     (resolve_pc),
        .resolve_taken  (resolve_taken),
        .resolve_target (resolve_target),
        .blt_write      (blt_write),
        .blt_write_key  (blt_write_key),
        .blt_write_val  (blt_write_val),
        .blt_hit        (blt_hit),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .error          (error)
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic          taken;
        logic [AW-1:0] target;
    } pred_t;

    typedef struct {
        logic          blt_write;
        logic [AW-1:0] key;
        logic [AW-1:0] val;
        logic          hit;
        logic          flush;
        logic [AW-1:0] flush_pc;
        logic          error;
        logic [3:0]    count;
        logic          full;
    } exp_t;

    pred_t         model_q[$];
    exp_t          exp_q[$];
    logic [AW-1:0] m_key = '0;
    logic [AW-1:0] m_val = '0;
    logic          m_hit = 1'b0;
    logic [AW-1:0] m_fpc = '0;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: consume this cycle's inputs, push the expected post-edge outputs.
    task automatic model_step();
        exp_t  e;
        pred_t h;
        pred_t n;
        bit    was_full;
        bit    popped;
        bit    mis;
        e.blt_write = 1'b0;
        e.flush     = 1'b0;
        e.error     = 1'b0;
        if (reset) begin
            model_q.delete();
            m_key = '0; m_val = '0; m_hit = 1'b0; m_fpc = '0;
        end else begin
            was_full = (model_q.size() == DEPTH);
            popped   = 1'b0;
            if (resolve) begin
                if (model_q.size() == 0) begin
                    e.error = 1'b1;
                end else begin
                    popped = 1'b1;
                    h = model_q.pop_front();
                    if (h.pc != resolve_pc) begin
                        e.error = 1'b1;
                        e.flush = 1'b1;
                    end else begin
                        e.blt_write = 1'b1;
                        m_key = resolve_pc;
                        m_val = resolve_target;
                        m_hit = resolve_taken;
                        mis = (h.taken != resolve_taken) ||
                              (resolve_taken && h.target != resolve_target);
                        if (mis) e.flush = 1'b1;
                    end
                    if (e.flush) m_fpc = resolve_taken ? resolve_target : AW'(resolve_pc + 16'd1);
                end
            end
            if (e.flush) begin
                model_q.delete();
            end else if (push) begin
                if (was_full && !popped) begin
                    e.error = 1'b1;
                end else begin
                    n.pc = push_pc; n.taken = push_taken; n.target = push_target;
                    model_q.push_back(n);
                end
            end
        end
        e.key      = m_key;
        e.val      = m_val;
        e.hit      = m_hit;
        e.flush_pc = m_fpc;
        e.count    = 4'(model_q.size());
        e.full     = (model_q.size() == DEPTH);
        exp_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val("blt_write", 32'(blt_write),     32'(e.blt_write));
            check_val("blt_key",   32'(blt_write_key), 32'(e.key));
            check_val("blt_val",   32'(blt_write_val), 32'(e.val));
            check_val("blt_hit",   32'(blt_hit),       32'(e.hit));
            check_val("flush",     32'(flush),         32'(e.flush));
            check_val("flush_pc",  32'(flush_pc),      32'(e.flush_pc));
            check_val("error",     32'(error),         32'(e.error));
            check_val("count",     32'(count),         32'(e.count));
            check_val("full",      32'(full),          32'(e.full));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic drive(input logic p, input logic [AW-1:0] ppc, input logic pt, input logic [AW-1:0] ptg,
                         input logic r, input logic [AW-1:0] rpc, input logic rt, input logic [AW-1:0] rtg);
        push = p; push_pc = ppc; push_taken = pt; push_target = ptg;
        resolve = r; resolve_pc = rpc; resolve_taken = rt; resolve_target = rtg;
        cycle();
    endtask

    task automatic do_push(input logic [AW-1:0] pc, input logic t, input logic [AW-1:0] tg);
        drive(1'b1, pc, t, tg, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_resolve(input logic [AW-1:0] pc, input logic t, input logic [AW-1:0] tg);
        drive(1'b0, '0, 1'b0, '0, 1'b1, pc, t, tg);
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        reset = 1'b1;
        push = 1'b0; push_pc = '0; push_taken = 1'b0; push_target = '0;
        resolve = 1'b0; resolve_pc = '0; resolve_taken = 1'b0; resolve_target = '0;
        cycle();
        cycle();
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_flush", 32'(flush), 32'd0);
        reset = 1'b0;
        idle();

        // Correct taken prediction trains the BLT.
        do_push(16'h0010, 1'b1, 16'h0040);
        do_resolve(16'h0010, 1'b1, 16'h0040);
        check_val("t1_write", 32'(blt_write), 32'd1);
        check_val("t1_key", 32'(blt_write_key), 32'h10);
        check_val("t1_val", 32'(blt_write_val), 32'h40);
        check_val("t1_flush", 32'(flush), 32'd0);

        // Predicted not-taken, actually taken.
        do_push(16'h0020, 1'b0, 16'h0000);
        do_resolve(16'h0020, 1'b1, 16'h0080);
        check_val("t2_flush", 32'(flush), 32'd1);
        check_val("t2_fpc", 32'(flush_pc), 32'h80);
        check_val("t2_hit", 32'(blt_hit), 32'd1);
        idle();

        // Mispredict discards younger entries and drops the same-cycle push.
        do_push(16'h0030, 1'b1, 16'h0050);
        do_push(16'h0031, 1'b0, 16'h0000);
        do_push(16'h0032, 1'b0, 16'h0000);
        drive(1'b1, 16'h0033, 1'b0, 16'h0000, 1'b1, 16'h0030, 1'b0, 16'h0000);
        check_val("t3_fpc", 32'(flush_pc), 32'h31);
        check_val("t3_count", 32'(count), 32'd0);
        check_val("t3_err", 32'(error), 32'd0);
        idle();

        // Fill, overflow, then push+resolve while full.
        for (int i = 0; i < DEPTH; i++) do_push(AW'(16'h0100 + i), 1'b0, 16'h0000);
        check_val("t4_full", 32'(full), 32'd1);
        do_push(16'h0108, 1'b0, 16'h0000);
        check_val("t4_ovf_err", 32'(error), 32'd1);
        drive(1'b1, 16'h0109, 1'b1, 16'h0200, 1'b1, 16'h0100, 1'b0, 16'h0000);
        check_val("t4_pp_count", 32'(count), 32'd8);
        check_val("t4_pp_err", 32'(error), 32'd0);
        for (int i = 1; i < DEPTH; i++) do_resolve(AW'(16'h0100 + i), 1'b0, 16'h0000);
        do_resolve(16'h0109, 1'b1, 16'h0200);
        check_val("t4_drain", 32'(count), 32'd0);

        // Resolve on empty, with a same-cycle push into the empty queue.
        drive(1'b1, 16'h0060, 1'b0, 16'h0000, 1'b1, 16'h0055, 1'b0, 16'h0000);
        check_val("t5_err", 32'(error), 32'd1);
        check_val("t5_write", 32'(blt_write), 32'd0);
        check_val("t5_cnt", 32'(count), 32'd1);
        do_resolve(16'h0060, 1'b0, 16'h0000);
        // Fall-through wraps at the top of the address space.
        do_push(16'hFFFF, 1'b1, 16'h1234);
        do_resolve(16'hFFFF, 1'b0, 16'h0000);
        check_val("t5_wrap", 32'(flush_pc), 32'h0);
        check_val("t5_wrap_fl", 32'(flush), 32'd1);
        // Head PC mismatch: error plus redirect, no training.
        do_push(16'h0070, 1'b1, 16'h0090);
        do_resolve(16'h0071, 1'b1, 16'h00A0);
        check_val("t5_mm_err", 32'(error), 32'd1);
        check_val("t5_mm_wr", 32'(blt_write), 32'd0);
        check_val("t5_mm_fpc", 32'(flush_pc), 32'hA0);

        // Reset mid-operation with a resolve pending.
        for (int i = 0; i < 5; i++) do_push(AW'(16'h0300 + i), 1'b1, 16'h0400);
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b1, 16'h0300, 1'b1, 16'h0400);
        check_val("t6_count", 32'(count), 32'd0);
        check_val("t6_key", 32'(blt_write_key), 32'd0);
        check_val("t6_fpc", 32'(flush_pc), 32'd0);
        reset = 1'b0;
        idle();

        // Random traffic, mostly well-formed resolves against the head.
        for (int n = 0; n < 600; n++) begin
            logic          p, r, rt;
            logic [AW-1:0] rpc, rtg, ptg;
            reset = ($urandom_range(0, 199) == 0);
            p   = ($urandom_range(0, 99) < 60);
            r   = ($urandom_range(0, 99) < 45);
            ptg = $urandom_range(0, 1) ? 16'h0400 : 16'h0800;
            rpc = AW'($urandom);
            rt  = 1'($urandom_range(0, 1));
            rtg = $urandom_range(0, 1) ? 16'h0400 : 16'h0800;
            if (model_q.size() > 0 && $urandom_range(0, 9) < 8) begin
                rpc = model_q[0].pc;
                if ($urandom_range(0, 9) < 7) begin
                    rt  = model_q[0].taken;
                    rtg = model_q[0].target;
                end
            end
            drive(p, AW'($urandom), 1'($urandom_range(0, 1)), ptg, r, rpc, rt, rtg);
        end
        reset = 1'b0;
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
